// File: rtl/parity_link_pkg.sv
// Shared definitions for the parity serial link controller.
// Holds the TX/RX state encodings and the frame geometry constants.
package parity_link_pkg;

  localparam int   FRAME_BITS = 7;
  localparam int   DATA_BITS  = 4;
  localparam logic IDLE_LVL   = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_D,
    TX_PAR,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_D,
    RX_PAR,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

endpackage

// File: rtl/parity_link_ctrl_if.sv
// Nibble-side bus of the parity link controller.
//   tx_data/tx_valid/tx_ready : nibble to send, valid/ready handshake
//   rx_data/rx_valid          : received nibble, one-cycle pulse on good stop
//   rx_perr                   : parity error qualifier for rx_valid
//   rx_ferr                   : one-cycle pulse on a bad stop bit
// master = nibble datapath, slave = link controller.
interface parity_link_ctrl_if;
  import parity_link_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_perr;
  logic                 rx_ferr;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_perr, rx_ferr
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_perr, rx_ferr
  );

endinterface

// File: rtl/parity_link_ctrl_parity4.sv
// Even-parity generator for one nibble.
//   d : 4-bit data in
//   p : parity bit making the ones count over d and p even
module parity4
  import parity_link_pkg::*;
(
  input  logic [DATA_BITS-1:0] d,
  output logic                 p
);

  assign p = ^d;

endmodule

// File: rtl/parity_link_ctrl.sv
// Serial link controller: frames nibbles as start,d0..d3,parity,stop on
// ser_out and checks incoming frames on ser_in, with a saturating error count.
//   clk, rst_n : clock, synchronous active-low reset
//   link       : nibble-side bus (slave modport)
//   ser_out    : serial line out, idles high
//   ser_in     : serial line in, idles high
//   err_cnt    : saturating count of parity + framing errors
//   err_clr    : synchronous clear of err_cnt, wins over a same-edge error
module parity_link_ctrl
  import parity_link_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parity_link_ctrl_if.slave    link,
  output logic                 ser_out,
  input  logic                 ser_in,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  // ---------------- TX ----------------
  tx_state_t            tx_state, tx_state_nx;
  logic [1:0]           tx_cnt, tx_cnt_nx;
  logic [DATA_BITS-1:0] tx_buf;
  logic                 tx_par;
  logic                 tx_hs;
  logic                 tx_ready_q, tx_ready_nx;
  logic                 ser_out_q, ser_out_nx;

  parity4 u_tx_par (.d(tx_buf), .p(tx_par));

  assign tx_hs = link.tx_valid & tx_ready_q;

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    case (tx_state)
      TX_IDLE:  if (tx_hs) tx_state_nx = TX_START;
      TX_START: begin
        tx_state_nx = TX_D;
        tx_cnt_nx   = 2'd0;
      end
      TX_D: begin
        if (tx_cnt == 2'd3) tx_state_nx = TX_PAR;
        else                tx_cnt_nx   = tx_cnt + 2'd1;
      end
      TX_PAR:   tx_state_nx = TX_STOP;
      TX_STOP:  tx_state_nx = tx_hs ? TX_START : TX_IDLE;
      default:  tx_state_nx = TX_IDLE;
    endcase
  end

  // Line level and ready are decoded from the next state so both leave the
  // flops aligned with the state they describe.
  always_comb begin
    ser_out_nx = IDLE_LVL;
    case (tx_state_nx)
      TX_START: ser_out_nx = 1'b0;
      TX_D:     ser_out_nx = tx_buf[tx_cnt_nx];
      TX_PAR:   ser_out_nx = tx_par;
      default:  ser_out_nx = IDLE_LVL;
    endcase
    tx_ready_nx = (tx_state_nx == TX_IDLE) || (tx_state_nx == TX_STOP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_buf     <= '0;
      tx_ready_q <= 1'b1;
      ser_out_q  <= IDLE_LVL;
    end else begin
      tx_state   <= tx_state_nx;
      tx_cnt     <= tx_cnt_nx;
      tx_ready_q <= tx_ready_nx;
      ser_out_q  <= ser_out_nx;
      if (tx_hs) tx_buf <= link.tx_data;
    end
  end

  // ---------------- RX ----------------
  rx_state_t            rx_state, rx_state_nx;
  logic [1:0]           rx_cnt, rx_cnt_nx;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_p;
  logic                 rx_par;
  logic                 valid_nx, ferr_nx, perr_nx;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, rx_perr_q, rx_ferr_q;
  logic                 err_inc;

  parity4 u_rx_par (.d(rx_sh), .p(rx_par));

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    valid_nx    = 1'b0;
    ferr_nx     = 1'b0;
    perr_nx     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!ser_in) begin
          rx_state_nx = RX_D;
          rx_cnt_nx   = 2'd0;
        end
      end
      RX_D: begin
        if (rx_cnt == 2'd3) rx_state_nx = RX_PAR;
        else                rx_cnt_nx   = rx_cnt + 2'd1;
      end
      RX_PAR:  rx_state_nx = RX_STOP;
      RX_STOP: begin
        if (ser_in) begin
          valid_nx    = 1'b1;
          perr_nx     = (rx_p != rx_par);
          rx_state_nx = RX_IDLE;
        end else begin
          ferr_nx     = 1'b1;
          rx_state_nx = RX_WAIT;
        end
      end
      // A held-low line after a bad stop must not be taken as a new start.
      RX_WAIT: if (ser_in) rx_state_nx = RX_IDLE;
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  // Counted on the same edge the flags are registered so err_cnt moves
  // together with the rx_valid/rx_ferr pulse.
  assign err_inc = (valid_nx & perr_nx) | ferr_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_sh      <= '0;
      rx_p       <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      rx_state   <= rx_state_nx;
      rx_cnt     <= rx_cnt_nx;
      rx_valid_q <= valid_nx;
      rx_perr_q  <= perr_nx;
      rx_ferr_q  <= ferr_nx;
      if (rx_state == RX_D)   rx_sh[rx_cnt] <= ser_in;
      if (rx_state == RX_PAR) rx_p          <= ser_in;
      if (valid_nx)           rx_data_q     <= rx_sh;
      if (err_clr)
        err_cnt <= '0;
      else if (err_inc && (err_cnt != '1))
        err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign ser_out       = ser_out_q;
  assign link.tx_ready = tx_ready_q;
  assign link.rx_data  = rx_data_q;
  assign link.rx_valid = rx_valid_q;
  assign link.rx_perr  = rx_perr_q;
  assign link.rx_ferr  = rx_ferr_q;

endmodule

// File: tb/tb_parity_link_ctrl.sv
module tb_parity_link_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ser_drv = 1'b1;
  logic       loop = 1'b0;
  logic       err_clr = 1'b0;
  logic       err_clr2 = 1'b0;
  logic       ser_out1, ser_out2, ser_in_w;
  logic [7:0] err_cnt1;
  logic [1:0] err_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  parity_link_ctrl_if lk ();
  parity_link_ctrl_if lk2 ();

  parity_link_ctrl #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .link(lk.slave), .ser_out(ser_out1),
    .ser_in(ser_in_w), .err_cnt(err_cnt1), .err_clr(err_clr)
  );

  parity_link_ctrl #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .link(lk2.slave), .ser_out(ser_out2),
    .ser_in(ser_in_w), .err_cnt(err_cnt2), .err_clr(err_clr2)
  );

  assign ser_in_w = loop ? ser_out1 : ser_drv;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame bit i is the i-th bit on the line: start, d0..d3, parity, stop.
  function automatic logic [6:0] mk_frame(input logic [3:0] d, input logic flip, input logic bad);
    logic p;
    p = (d[0] ^ d[1] ^ d[2] ^ d[3]) ^ flip;
    return {~bad, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [6:0] fr);
    for (int i = 0; i < 7; i++) begin
      ser_drv = fr[i];
      step();
    end
  endtask

  // ---------------- loopback monitor / scoreboard ----------------
  logic       mon = 1'b0;
  logic       q_bits[$];
  logic [3:0] q_nib[$];
  int         q_cyc[$];
  int         hs_log[$];
  int         cyc = 0;
  int         rx_cnt = 0;
  logic       m_eb;
  logic [6:0] m_fr;

  always @(negedge clk) begin
    if (mon) begin
      m_eb = (q_bits.size() > 0) ? q_bits.pop_front() : 1'b1;
      check("mon_ser_out", ser_out1, m_eb);
      check("mon_tx_ready", lk.tx_ready, (q_bits.size() == 0));
      if (lk.tx_valid && lk.tx_ready) begin
        m_fr = mk_frame(lk.tx_data, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) q_bits.push_back(m_fr[i]);
        q_nib.push_back(lk.tx_data);
        q_cyc.push_back(cyc + 8);
        hs_log.push_back(cyc + 1);
      end
      if (lk.rx_valid) begin
        rx_cnt++;
        if (q_nib.size() == 0) begin
          check("mon_rx_unexpected", 1, 0);
        end else begin
          check("mon_rx_data", lk.rx_data, q_nib.pop_front());
          check("mon_rx_lat", cyc, q_cyc.pop_front());
          check("mon_rx_perr", lk.rx_perr, 0);
        end
      end
      check("mon_rx_ferr", lk.rx_ferr, 0);
      cyc++;
    end
  end

  task automatic do_reset();
    mon = 1'b0;
    loop = 1'b0;
    ser_drv = 1'b1;
    lk.tx_valid = 1'b0;
    err_clr = 1'b0;
    err_clr2 = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    q_bits.delete();
    q_nib.delete();
    q_cyc.delete();
    hs_log.delete();
    rx_cnt = 0;
    step();
  endtask

  typedef struct {
    logic [3:0] nib;
    logic       flip;
    logic       bad;
    logic       e_valid;
    logic [3:0] e_data;
    logic       e_perr;
    logic       e_ferr;
    logic [7:0] e_err;
  } vec_t;

  vec_t       vt[8];
  logic [6:0] seq;
  logic [6:0] fr;
  logic [3:0] d;
  logic       flip, bad;
  logic [3:0] model_data;
  int         model_err;
  int         hs_cnt;
  logic       hs;
  logic       seen;

  initial begin
    lk.tx_valid  = 1'b0;
    lk.tx_data   = '0;
    lk2.tx_valid = 1'b0;
    lk2.tx_data  = '0;

    vt[0] = '{4'h1, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 8'd0};
    vt[1] = '{4'h1, 1'b1, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 8'd1};
    vt[2] = '{4'h7, 1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 8'd1};
    vt[3] = '{4'hA, 1'b1, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 8'd2};
    vt[4] = '{4'h3, 1'b0, 1'b1, 1'b0, 4'hA, 1'b0, 1'b1, 8'd3};
    vt[5] = '{4'hF, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 8'd3};
    vt[6] = '{4'hC, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 8'd4};
    vt[7] = '{4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 8'd5};

    // Reset values
    step();
    step();
    check("rst_tx_ready", lk.tx_ready, 1);
    check("rst_ser_out", ser_out1, 1);
    check("rst_rx_data", lk.rx_data, 0);
    check("rst_rx_valid", lk.rx_valid, 0);
    check("rst_rx_perr", lk.rx_perr, 0);
    check("rst_rx_ferr", lk.rx_ferr, 0);
    check("rst_err_cnt", err_cnt1, 0);

    // Loopback of 4'b1011
    do_reset();
    loop = 1'b1;
    seq = 7'b1110110;
    lk.tx_data = 4'b1011;
    lk.tx_valid = 1'b1;
    step();
    lk.tx_valid = 1'b0;
    lk.tx_data = 4'h0;
    check("lb_ser_out0", ser_out1, seq[0]);
    check("lb_ready_busy", lk.tx_ready, 0);
    for (int i = 1; i < 7; i++) begin
      step();
      check("lb_ser_out", ser_out1, seq[i]);
    end
    check("lb_ready_stop", lk.tx_ready, 1);
    step();
    check("lb_rx_valid", lk.rx_valid, 1);
    check("lb_rx_data", lk.rx_data, 4'b1011);
    check("lb_rx_perr", lk.rx_perr, 0);
    check("lb_err_cnt", err_cnt1, 0);
    step();
    check("lb_rx_valid_pulse", lk.rx_valid, 0);

    // Table-driven injected frames
    do_reset();
    for (int k = 0; k < 8; k++) begin
      send_bits(mk_frame(vt[k].nib, vt[k].flip, vt[k].bad));
      check("tbl_valid", lk.rx_valid, vt[k].e_valid);
      check("tbl_ferr", lk.rx_ferr, vt[k].e_ferr);
      check("tbl_data", lk.rx_data, vt[k].e_data);
      if (vt[k].e_valid) check("tbl_perr", lk.rx_perr, vt[k].e_perr);
      check("tbl_err_cnt", err_cnt1, vt[k].e_err);
      ser_drv = 1'b1;
      step();
      check("tbl_valid_drop", lk.rx_valid, 0);
      check("tbl_ferr_drop", lk.rx_ferr, 0);
      step();
    end

    // Framing error followed by a held-low line
    do_reset();
    send_bits(mk_frame(4'h5, 1'b0, 1'b1));
    check("fe_ferr", lk.rx_ferr, 1);
    check("fe_valid", lk.rx_valid, 0);
    check("fe_err_cnt", err_cnt1, 1);
    seen = 1'b0;
    ser_drv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      seen = seen | lk.rx_valid | lk.rx_ferr;
    end
    ser_drv = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | lk.rx_valid | lk.rx_ferr;
    end
    check("fe_no_false_start", seen, 0);
    check("fe_err_cnt_after", err_cnt1, 1);

    // Saturation and clear on the narrow counter
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      send_bits(mk_frame(4'($urandom_range(0, 15)), 1'b1, 1'b0));
      check("sat_err_cnt", err_cnt2, (k > 3) ? 3 : k);
      ser_drv = 1'b1;
      step();
    end
    fr = mk_frame(4'h9, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      ser_drv = fr[i];
      if (i == 6) err_clr2 = 1'b1;
      step();
    end
    err_clr2 = 1'b0;
    check("sat_clr_err_cnt", err_cnt2, 0);
    check("sat_clr_valid", lk2.rx_valid, 1);
    check("sat_clr_perr", lk2.rx_perr, 1);
    check("sat_wide_err_cnt", err_cnt1, 6);
    ser_drv = 1'b1;
    step();

    // Reset in the middle of a frame
    do_reset();
    loop = 1'b1;
    lk.tx_data = 4'h9;
    lk.tx_valid = 1'b1;
    step();
    lk.tx_valid = 1'b0;
    step();
    step();
    check("mr_d1", ser_out1, 0);
    rst_n = 1'b0;
    step();
    check("mr_ser_out", ser_out1, 1);
    check("mr_tx_ready", lk.tx_ready, 1);
    rst_n = 1'b1;
    seen = lk.rx_valid | lk.rx_ferr;
    for (int i = 0; i < 12; i++) begin
      step();
      seen = seen | lk.rx_valid | lk.rx_ferr;
    end
    check("mr_no_rx", seen, 0);

    // Back-to-back: tx_valid held with 0, F, 6
    do_reset();
    loop = 1'b1;
    mon = 1'b1;
    hs_cnt = 0;
    lk.tx_data = 4'h0;
    lk.tx_valid = 1'b1;
    for (int c = 0; c < 40 && hs_cnt < 3; c++) begin
      hs = lk.tx_valid && lk.tx_ready;
      step();
      if (hs) begin
        hs_cnt++;
        if (hs_cnt == 1) lk.tx_data = 4'hF;
        else if (hs_cnt == 2) lk.tx_data = 4'h6;
        else lk.tx_valid = 1'b0;
      end
    end
    lk.tx_valid = 1'b0;
    check("b2b_hs_count", hs_cnt, 3);
    repeat (12) step();
    check("b2b_rx_count", rx_cnt, 3);
    check("b2b_hs_log", hs_log.size(), 3);
    if (hs_log.size() == 3) begin
      check("b2b_gap1", hs_log[1] - hs_log[0], 7);
      check("b2b_gap2", hs_log[2] - hs_log[1], 7);
    end

    // Random loopback traffic
    do_reset();
    loop = 1'b1;
    mon = 1'b1;
    lk.tx_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      hs = lk.tx_valid && lk.tx_ready;
      step();
      if (hs || !lk.tx_valid) begin
        lk.tx_valid = ($urandom_range(0, 3) != 0);
        lk.tx_data = 4'($urandom_range(0, 15));
      end
    end
    lk.tx_valid = 1'b0;
    repeat (12) step();
    check("rnd_lb_drained", q_nib.size(), 0);
    check("rnd_lb_bits_drained", q_bits.size(), 0);
    check("rnd_lb_any_rx", (rx_cnt > 10), 1);
    mon = 1'b0;

    // Random injected frames against the frame-level model
    do_reset();
    model_data = '0;
    model_err = 0;
    for (int k = 0; k < 30; k++) begin
      d = 4'($urandom_range(0, 15));
      flip = ($urandom_range(0, 2) == 0);
      bad = ($urandom_range(0, 5) == 0);
      send_bits(mk_frame(d, flip, bad));
      if (bad) begin
        model_err++;
        check("rnd_ferr", lk.rx_ferr, 1);
        check("rnd_valid", lk.rx_valid, 0);
      end else begin
        model_data = d;
        if (flip) model_err++;
        check("rnd_ferr", lk.rx_ferr, 0);
        check("rnd_valid", lk.rx_valid, 1);
        check("rnd_perr", lk.rx_perr, flip);
      end
      check("rnd_data", lk.rx_data, model_data);
      check("rnd_err_cnt", err_cnt1, (model_err > 255) ? 255 : model_err);
      ser_drv = 1'b1;
      repeat ($urandom_range(1, 3)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
